// File: rtl/sub_serial.sv
// Digit-serial unsigned subtractor: O = I0 - I1 - BIN, DIGIT bits per clock.
// Valid/ready on both sides; borrow is chained between digits as an inverted carry.
module sub_serial #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             CLK,
   input  logic             RESETN,
   input  logic [WIDTH-1:0] I0,
   input  logic [WIDTH-1:0] I1,
   input  logic             BIN,
   input  logic             VALID_IN,
   output logic             READY_OUT,
   output logic [WIDTH-1:0] O,
   output logic             BOUT,
   output logic             ZERO,
   output logic             VALID_OUT,
   input  logic             READY_IN
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic [WIDTH-1:0] res_nxt;
   logic [DIGIT:0]   sum;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             last;
   logic             accept;

   // One digit per clock; the new digit enters the result from the top.
   always_comb begin
      sum = {1'b0, a_sr[DIGIT-1:0]}
          + {1'b0, ~b_sr[DIGIT-1:0]}
          + {{DIGIT{1'b0}}, carry};
      res_nxt = WIDTH'({sum[DIGIT-1:0], res_sr} >> DIGIT);
      last    = (cnt == CW'(N - 1));
      accept  = VALID_IN & READY_OUT;
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      READY_OUT = 1'b0;
      VALID_OUT = 1'b0;
      unique case (state)
         IDLE: begin
            READY_OUT = 1'b1;
            if (VALID_IN) state_nxt = RUN;
         end
         RUN: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            VALID_OUT = 1'b1;
            READY_OUT = READY_IN;
            if (READY_IN) state_nxt = VALID_IN ? RUN : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         O      <= '0;
         BOUT   <= 1'b0;
         ZERO   <= 1'b0;
      end else if (accept) begin
         a_sr   <= I0;
         b_sr   <= I1;
         res_sr <= '0;
         carry  <= ~BIN;
         cnt    <= '0;
      end else if (state == RUN) begin
         a_sr   <= a_sr >> DIGIT;
         b_sr   <= b_sr >> DIGIT;
         res_sr <= res_nxt;
         carry  <= sum[DIGIT];
         cnt    <= cnt + CW'(1);
         if (last) begin
            O    <= res_nxt;
            BOUT <= ~sum[DIGIT];
            ZERO <= (res_nxt == '0);
         end
      end
   end

endmodule

// File: tb/tb_sub_serial.sv
// Bench for sub_serial: directed cases, backpressure, random stream, reset
// mid-run; results checked through an expectation queue.
module tb_sub_serial;

   localparam int W = 16;
   localparam int D = 4;

   typedef struct packed {
      logic [W-1:0] o;
      logic         bout;
      logic         zero;
   } exp_t;

   logic         CLK = 1'b0;
   logic         RESETN = 1'b0;
   logic [W-1:0] I0 = '0;
   logic [W-1:0] I1 = '0;
   logic         BIN = 1'b0;
   logic         VALID_IN = 1'b0;
   logic         READY_OUT;
   logic [W-1:0] O;
   logic         BOUT;
   logic         ZERO;
   logic         VALID_OUT;
   logic         READY_IN = 1'b1;

   int   checks = 0;
   int   failures = 0;
   int   pushed = 0;
   int   popped = 0;
   bit   rand_rdy = 1'b0;
   exp_t sb[$];

   sub_serial #(.WIDTH(W), .DIGIT(D)) dut (
      .CLK(CLK),
      .RESETN(RESETN),
      .I0(I0),
      .I1(I1),
      .BIN(BIN),
      .VALID_IN(VALID_IN),
      .READY_OUT(READY_OUT),
      .O(O),
      .BOUT(BOUT),
      .ZERO(ZERO),
      .VALID_OUT(VALID_OUT),
      .READY_IN(READY_IN)
   );

   always #5 CLK = ~CLK;

   function automatic exp_t model(input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  input logic bin);
      logic [W:0] d;
      exp_t e;
      d = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
      e.o = d[W-1:0];
      e.bout = d[W];
      e.zero = (d[W-1:0] == '0);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Scoreboard: push on accept, pop and compare on consume.
   always @(negedge CLK) begin
      if (RESETN) begin
         if (VALID_OUT && READY_IN) begin
            checks++;
            assert (sb.size() != 0) else begin
               failures++;
               $error("FAIL sb_underflow got=%0d exp=nonzero", sb.size());
            end
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               popped++;
               chk("sb_o", {16'h0, O}, {16'h0, e.o});
               chk("sb_bout", {31'h0, BOUT}, {31'h0, e.bout});
               chk("sb_zero", {31'h0, ZERO}, {31'h0, e.zero});
            end
         end
         if (VALID_IN && READY_OUT) begin
            sb.push_back(model(I0, I1, BIN));
            pushed++;
         end
      end
   end

   always @(posedge CLK) begin
      #1;
      if (rand_rdy) READY_IN = ($urandom_range(0, 3) != 0);
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bin);
      int n;
      I0 = a;
      I1 = b;
      BIN = bin;
      VALID_IN = 1'b1;
      n = 0;
      @(negedge CLK);
      while (!READY_OUT && n < 50) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 50) chk("send_timeout", 32'(n), 32'd0);
      @(posedge CLK);
      #1;
      VALID_IN = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      do begin
         @(posedge CLK);
         #1;
         lat++;
      end while (!VALID_OUT && lat < 20);
   endtask

   task automatic directed(input string tag, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic bin,
                           input logic [W-1:0] eo, input logic eb);
      int lat;
      send(a, b, bin);
      wait_valid(lat);
      chk({tag, "_lat"}, 32'(lat), 32'd4);
      chk({tag, "_o"}, {16'h0, O}, {16'h0, eo});
      chk({tag, "_bout"}, {31'h0, BOUT}, {31'h0, eb});
      @(posedge CLK);
      #1;
   endtask

   initial begin
      int lat;
      int n;

      #2;
      chk("rst_o", {16'h0, O}, 32'h0);
      chk("rst_bout", {31'h0, BOUT}, 32'h0);
      chk("rst_zero", {31'h0, ZERO}, 32'h0);
      chk("rst_vout", {31'h0, VALID_OUT}, 32'h0);
      repeat (2) @(posedge CLK);
      #1;
      RESETN = 1'b1;
      #1;
      chk("rst_rdy", {31'h0, READY_OUT}, 32'h1);

      directed("t1", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0);
      chk("t1_zero", {31'h0, ZERO}, 32'h0);
      directed("t2", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);
      directed("t3", 16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0);
      chk("t3_zero", {31'h0, ZERO}, 32'h1);
      directed("t4", 16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1);
      directed("t5", 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1);
      directed("t6", 16'h3C3C, 16'hFFFF, 1'b1, 16'h3C3C, 1'b1);
      directed("t7", 16'hA5A5, 16'hA5A5, 1'b0, 16'h0000, 1'b0);
      chk("t7_zero", {31'h0, ZERO}, 32'h1);

      // Backpressure, then a back-to-back accept on release
      READY_IN = 1'b0;
      send(16'hABCD, 16'h1234, 1'b0);
      wait_valid(lat);
      chk("bp_lat", 32'(lat), 32'd4);
      I0 = 16'h00FF;
      I1 = 16'h0F0F;
      BIN = 1'b0;
      VALID_IN = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         chk("bp_o", {16'h0, O}, 32'h9999);
         chk("bp_bout", {31'h0, BOUT}, 32'h0);
         chk("bp_vout", {31'h0, VALID_OUT}, 32'h1);
         chk("bp_rdy", {31'h0, READY_OUT}, 32'h0);
         @(posedge CLK);
         #1;
      end
      READY_IN = 1'b1;
      @(negedge CLK);
      chk("b2b_rdy", {31'h0, READY_OUT}, 32'h1);
      @(posedge CLK);
      #1;
      VALID_IN = 1'b0;
      wait_valid(lat);
      chk("b2b_lat", 32'(lat), 32'd4);
      chk("b2b_o", {16'h0, O}, 32'hF1F0);
      chk("b2b_bout", {31'h0, BOUT}, 32'h1);
      @(posedge CLK);
      #1;

      // Random stream with gaps, random backpressure and input churn
      rand_rdy = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge CLK);
            #1;
         end
         send(W'($urandom), W'($urandom), 1'($urandom));
         I0 = W'($urandom);
         I1 = W'($urandom);
         BIN = 1'($urandom);
      end
      @(posedge CLK);
      #2;
      rand_rdy = 1'b0;
      READY_IN = 1'b1;
      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(posedge CLK);
         #1;
         n++;
      end
      chk("rnd_drain", 32'(sb.size()), 32'd0);
      chk("rnd_count", 32'(popped), 32'(pushed));
      chk("rnd_total", 32'(pushed), 32'd1009);

      // Reset two digit cycles into a run
      send(16'h1111, 16'h2222, 1'b0);
      repeat (2) @(posedge CLK);
      #1;
      RESETN = 1'b0;
      #1;
      chk("mid_o", {16'h0, O}, 32'h0);
      chk("mid_bout", {31'h0, BOUT}, 32'h0);
      chk("mid_zero", {31'h0, ZERO}, 32'h0);
      chk("mid_vout", {31'h0, VALID_OUT}, 32'h0);
      chk("mid_sb", 32'(sb.size()), 32'd1);
      sb.delete();
      pushed--;
      @(posedge CLK);
      #1;
      RESETN = 1'b1;
      #1;
      chk("mid_rdy", {31'h0, READY_OUT}, 32'h1);
      n = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         if (VALID_OUT) n++;
      end
      chk("mid_novalid", 32'(n), 32'd0);
      @(posedge CLK);
      #1;
      directed("post", 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0);
      chk("post_count", 32'(popped), 32'(pushed));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
